// File: rtl/ladybird_axi_ram_if.sv
// AXI link between the ladybird MMU master port and the on-chip RAM responder.
// The slave modport is the view seen by ladybird_axi_ram.
interface ladybird_axi_interface #(
    parameter int XLEN = 32
);
    logic            awvalid;
    logic            awready;
    logic [XLEN-1:0] awaddr;
    logic            wvalid;
    logic            wready;
    logic [XLEN-1:0] wdata;
    logic [3:0]      wstrb;
    logic            bvalid;
    logic            bready;
    logic [1:0]      bresp;
    logic            arvalid;
    logic            arready;
    logic [XLEN-1:0] araddr;
    logic            rvalid;
    logic            rready;
    logic [XLEN-1:0] rdata;
    logic [1:0]      rresp;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/ladybird_axi_ram.sv
// Word-organised AXI responder RAM with independent one-outstanding read and write FSMs.
// Optional feature: define LADYBIRD_AXI_RAM_RANGE_CHECK_EN to answer out-of-range accesses with SLVERR.
module ladybird_axi_ram #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          DEPTH        = 4096,
    parameter int          READ_LATENCY = 1
) (
    input logic                  clk,
    input logic                  rst,
    ladybird_axi_interface.slave axi
);
    localparam int          IDX_W = $clog2(DEPTH);
    localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_e;

    logic [31:0] mem_q [DEPTH];

    wstate_e          wstate_q;
    logic [IDX_W-1:0] widx_q;
    logic             werr_q;
    logic [1:0]       bresp_q;

    rstate_e          rstate_q;
    logic [IDX_W-1:0] ridx_q;
    logic             rerr_q;
    logic [3:0]       rcnt_q;
    logic [31:0]      rdata_q;
    logic [1:0]       rresp_q;

    logic [31:0]      awOffset;
    logic [31:0]      arOffset;
    logic [IDX_W-1:0] awIdx;
    logic [IDX_W-1:0] arIdx;
    logic             awErr;
    logic             arErr;
    logic             awHs;
    logic             wHs;
    logic             arHs;
    logic [IDX_W-1:0] capIdx;
    logic             capErr;
    logic             unusedBits;

    assign awOffset = axi.awaddr - BASE_ADDR;
    assign arOffset = axi.araddr - BASE_ADDR;
    assign awIdx    = awOffset[IDX_W+1:2];
    assign arIdx    = arOffset[IDX_W+1:2];

`ifdef LADYBIRD_AXI_RAM_RANGE_CHECK_EN
    assign awErr = (axi.awaddr < BASE_ADDR) || ({1'b0, awOffset} >= SPAN);
    assign arErr = (axi.araddr < BASE_ADDR) || ({1'b0, arOffset} >= SPAN);
`else
    assign awErr = 1'b0;
    assign arErr = 1'b0;
`endif

    assign unusedBits = ^{awOffset[31:IDX_W+2], awOffset[1:0],
                          arOffset[31:IDX_W+2], arOffset[1:0], SPAN};

    assign axi.awready = !rst && (wstate_q == W_IDLE);
    assign axi.wready  = !rst && (wstate_q == W_DATA);
    assign axi.bvalid  = (wstate_q == W_RESP);
    assign axi.bresp   = bresp_q;
    assign axi.arready = !rst && (rstate_q == R_IDLE);
    assign axi.rvalid  = (rstate_q == R_RESP);
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;

    assign awHs = axi.awvalid && axi.awready;
    assign wHs  = axi.wvalid && axi.wready;
    assign arHs = axi.arvalid && axi.arready;

    // Latency-1 reads capture straight from the AR address; longer ones from the latched index.
    assign capIdx = (rstate_q == R_IDLE) ? arIdx : ridx_q;
    assign capErr = (rstate_q == R_IDLE) ? arErr : rerr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q <= W_IDLE;
            widx_q   <= '0;
            werr_q   <= 1'b0;
            bresp_q  <= 2'b00;
        end else begin
            case (wstate_q)
                W_IDLE: if (awHs) begin
                    widx_q   <= awIdx;
                    werr_q   <= awErr;
                    wstate_q <= W_DATA;
                end
                W_DATA: if (wHs) begin
                    bresp_q  <= werr_q ? 2'b10 : 2'b00;
                    wstate_q <= W_RESP;
                end
                W_RESP: if (axi.bready) begin
                    bresp_q  <= 2'b00;
                    wstate_q <= W_IDLE;
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    // Array has no reset; a completed W beat survives a later reset.
    always_ff @(posedge clk) begin
        if (wHs && !werr_q) begin
            for (int b = 0; b < 4; b++) begin
                if (axi.wstrb[b]) begin
                    mem_q[widx_q][8*b +: 8] <= axi.wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q <= R_IDLE;
            ridx_q   <= '0;
            rerr_q   <= 1'b0;
            rcnt_q   <= 4'd0;
            rdata_q  <= 32'h0;
            rresp_q  <= 2'b00;
        end else begin
            case (rstate_q)
                R_IDLE: if (arHs) begin
                    ridx_q <= arIdx;
                    rerr_q <= arErr;
                    if (READ_LATENCY == 1) begin
                        rdata_q  <= capErr ? 32'h0 : mem_q[capIdx];
                        rresp_q  <= capErr ? 2'b10 : 2'b00;
                        rstate_q <= R_RESP;
                    end else begin
                        rcnt_q   <= 4'(READ_LATENCY - 1);
                        rstate_q <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    rcnt_q <= rcnt_q - 4'd1;
                    if (rcnt_q == 4'd1) begin
                        rdata_q  <= capErr ? 32'h0 : mem_q[capIdx];
                        rresp_q  <= capErr ? 2'b10 : 2'b00;
                        rstate_q <= R_RESP;
                    end
                end
                R_RESP: if (axi.rready) begin
                    rstate_q <= R_IDLE;
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end
endmodule
